// File: rtl/word_byte_serializer.sv
// ============================================================================
// Module   : word_byte_serializer
// Brief    : Splits a word into bytes and hands them one at a time to a
//            byte-wide transmitter over a start/done handshake.
// Revision : 1.0
// ============================================================================
`default_nettype none

module word_byte_serializer #(
    parameter int WORD_SIZE = 32,
    parameter int BYTE_SIZE = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_start,
    input  logic [WORD_SIZE-1:0] i_data,
    input  logic                 i_tx_done,
    output logic                 o_tx_start,
    output logic [BYTE_SIZE-1:0] o_tx_data,
    output logic                 o_busy,
    output logic                 o_done
);

    localparam int c_num_bytes = WORD_SIZE / BYTE_SIZE;
    localparam int c_cnt_w     = (c_num_bytes > 1) ? $clog2(c_num_bytes) : 1;
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_num_bytes - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [WORD_SIZE-1:0] r_shift;
    logic [WORD_SIZE-1:0] w_shift_next;
    logic [WORD_SIZE-1:0] w_shifted;
    logic [c_cnt_w-1:0]   r_count;
    logic [c_cnt_w-1:0]   w_count_next;
    logic [BYTE_SIZE-1:0] w_emit_byte;

    // The shift always moves the next byte into the emitting end of the word.
    generate
        if (c_num_bytes == 1) begin : g_single
            assign w_shifted = r_shift;
        end else if (MSB_FIRST) begin : g_shift_msb
            assign w_shifted = {r_shift[WORD_SIZE-BYTE_SIZE-1:0], {BYTE_SIZE{1'b0}}};
        end else begin : g_shift_lsb
            assign w_shifted = {{BYTE_SIZE{1'b0}}, r_shift[WORD_SIZE-1:BYTE_SIZE]};
        end

        if (MSB_FIRST) begin : g_emit_msb
            assign w_emit_byte = w_shift_next[WORD_SIZE-1 -: BYTE_SIZE];
        end else begin : g_emit_lsb
            assign w_emit_byte = w_shift_next[BYTE_SIZE-1:0];
        end
    endgenerate

    always_comb begin
        w_state_next = r_state;
        w_shift_next = r_shift;
        w_count_next = r_count;
        case (r_state)
            IDLE: begin
                if (i_start) begin
                    w_shift_next = i_data;
                    w_count_next = '0;
                    w_state_next = SEND;
                end
            end
            SEND: w_state_next = WAIT;
            WAIT: begin
                if (i_tx_done) begin
                    if (r_count == c_last) begin
                        w_state_next = DONE;
                    end else begin
                        w_shift_next = w_shifted;
                        w_count_next = r_count + 1'b1;
                        w_state_next = SEND;
                    end
                end
            end
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they line up with the
    // state they describe while still coming straight from flops.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_count    <= '0;
            o_tx_start <= 1'b0;
            o_tx_data  <= '0;
            o_busy     <= 1'b0;
            o_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_shift    <= w_shift_next;
            r_count    <= w_count_next;
            o_tx_start <= (w_state_next == SEND);
            o_busy     <= (w_state_next != IDLE);
            o_done     <= (w_state_next == DONE);
            if (w_state_next == SEND) begin
                o_tx_data <= w_emit_byte;
            end
        end
    end

endmodule

`default_nettype wire
